ysyx_22041461_divider: RTL

Multi-cycle RV64M divide/remainder unit in the EXE stage. It computes DIV, DIVU, REM, REMU and their W variants with a radix-2 restoring iteration. Its 64-bit result is the EXE result forwarded to the MEM stage as the address/data word. While the unit is busy, EXE stalls the pipeline through `div_ready_out`.

---
 rtl/ysyx_22041461_divider.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/ysyx_22041461_divider.sv
// ---------------------------------------------------------------------------
// ysyx_22041461_divider
//
// Multi-cycle RV64M divide/remainder unit for the EXE stage. It implements
// DIV, DIVU, REM, REMU and the W variants with a radix-2 restoring
// iteration: one quotient bit per BUSY cycle, 64 cycles for 64-bit ops and
// 32 cycles for W ops. Divide-by-zero and signed overflow do not iterate;
// they go straight from IDLE to DONE.
//
// Ports
//   clk           : single clock, rising edge
//   rst           : synchronous, active-high reset
//   div_valid_in  : request valid; taken only while div_ready_out=1
//   div_ctrl      : [2]=W (32-bit op), [1]=REM (1: remainder), [0]=U (unsigned)
//   div_src1      : dividend (rs1)
//   div_src2      : divisor (rs2)
//   div_flush     : kill the in-flight operation (mispredict / trap)
//   div_ready_out : 1 only in IDLE while rst=0
//   div_valid_out : one-cycle pulse during the DONE cycle
//   div_out       : registered result, stable until the next DONE
// ---------------------------------------------------------------------------
module ysyx_22041461_divider #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            div_valid_in,
    input  logic [2:0]      div_ctrl,
    input  logic [XLEN-1:0] div_src1,
    input  logic [XLEN-1:0] div_src2,
    input  logic            div_flush,
    output logic            div_ready_out,
    output logic            div_valid_out,
    output logic [XLEN-1:0] div_out
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Two's-complement negate when neg is set.
    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v,
                                                 input logic            neg);
        logic [XLEN-1:0] r;
        if (neg) begin
            r = ~v + 64'd1;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // W results are always sign-extended from bit 31, even for DIVUW/REMUW.
    function automatic logic [XLEN-1:0] w_ext(input logic [XLEN-1:0] v,
                                              input logic            w);
        logic [XLEN-1:0] r;
        if (w) begin
            r = {{32{v[31]}}, v[31:0]};
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Operand as seen at the operation width: low word sign- or zero-extended
    // for W ops, the full register otherwise.
    function automatic logic [XLEN-1:0] op_ext(input logic [XLEN-1:0] v,
                                               input logic            w,
                                               input logic            u);
        logic [XLEN-1:0] r;
        if (w && u) begin
            r = {32'd0, v[31:0]};
        end else if (w) begin
            r = {{32{v[31]}}, v[31:0]};
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Architectural state
    state_t          state_r;
    logic [6:0]      cnt_r;
    logic [XLEN-1:0] rem_r;
    logic [XLEN-1:0] quo_r;
    logic [XLEN-1:0] dvs_r;
    logic            qsign_r;
    logic            rsign_r;
    logic            w_r;
    logic            sel_rem_r;
    logic            valid_r;
    logic [XLEN-1:0] out_r;

    // Acceptance-cycle decode
    logic            op_w_s;
    logic            op_rem_s;
    logic            op_u_s;
    logic [XLEN-1:0] a1_s;
    logic [XLEN-1:0] a2_s;
    logic            sign1_s;
    logic            sign2_s;
    logic [XLEN-1:0] mag1_s;
    logic [XLEN-1:0] mag2_s;
    logic [XLEN-1:0] min_neg_s;
    logic            div_zero_s;
    logic            ovf_s;
    logic [XLEN-1:0] spec_res_s;
    logic            accept_s;

    // Iteration datapath
    logic [XLEN:0]   rem_sh_s;
    logic [XLEN+1:0] diff_s;
    logic [XLEN-1:0] rem_nxt_s;
    logic [XLEN-1:0] quo_nxt_s;
    logic [XLEN-1:0] busy_res_s;
    logic            unused_diff_s;

    assign div_ready_out = (state_r == ST_IDLE) && !rst;
    assign div_valid_out = valid_r;
    assign div_out       = out_r;

    // Decode the incoming request: width-adjusted operands, magnitudes,
    // signs and the two cases that bypass the iteration.
    always_comb begin
        op_w_s     = div_ctrl[2];
        op_rem_s   = div_ctrl[1];
        op_u_s     = div_ctrl[0];
        a1_s       = op_ext(div_src1, op_w_s, op_u_s);
        a2_s       = op_ext(div_src2, op_w_s, op_u_s);
        sign1_s    = !op_u_s && a1_s[XLEN-1];
        sign2_s    = !op_u_s && a2_s[XLEN-1];
        mag1_s     = cond_neg(a1_s, sign1_s);
        mag2_s     = cond_neg(a2_s, sign2_s);
        min_neg_s  = 64'h8000_0000_0000_0000;
        if (op_w_s) begin
            min_neg_s = 64'hFFFF_FFFF_8000_0000;
        end else begin
            min_neg_s = 64'h8000_0000_0000_0000;
        end
        div_zero_s = (a2_s == 64'd0);
        ovf_s      = !op_u_s && (a1_s == min_neg_s) && (a2_s == 64'hFFFF_FFFF_FFFF_FFFF);
        spec_res_s = 64'd0;
        if (div_zero_s) begin
            // quotient all ones, remainder = dividend
            spec_res_s = w_ext(op_rem_s ? a1_s : 64'hFFFF_FFFF_FFFF_FFFF, op_w_s);
        end else if (ovf_s) begin
            // quotient = dividend, remainder = 0
            spec_res_s = w_ext(op_rem_s ? 64'd0 : a1_s, op_w_s);
        end else begin
            spec_res_s = 64'd0;
        end
        accept_s   = div_valid_in && div_ready_out && !div_flush;
    end

    // One restoring step: shift {rem, quo} left, trial-subtract the divisor
    // magnitude and commit when the difference is non-negative. The final
    // signed/extended result is formed from the step outputs so it can be
    // registered on the same edge that enters DONE.
    always_comb begin
        rem_sh_s  = {rem_r, quo_r[XLEN-1]};
        diff_s    = {1'b0, rem_sh_s} - {2'b00, dvs_r};
        rem_nxt_s = rem_sh_s[XLEN-1:0];
        quo_nxt_s = {quo_r[XLEN-2:0], 1'b0};
        if (!diff_s[XLEN+1]) begin
            // remainder after a successful subtract is below the divisor,
            // so it always fits in XLEN bits
            rem_nxt_s = diff_s[XLEN-1:0];
            quo_nxt_s = {quo_r[XLEN-2:0], 1'b1};
        end else begin
            rem_nxt_s = rem_sh_s[XLEN-1:0];
            quo_nxt_s = {quo_r[XLEN-2:0], 1'b0};
        end
        if (sel_rem_r) begin
            busy_res_s = w_ext(cond_neg(rem_nxt_s, rsign_r), w_r);
        end else begin
            busy_res_s = w_ext(cond_neg(quo_nxt_s, qsign_r), w_r);
        end
        unused_diff_s = diff_s[XLEN];
    end

    // Control FSM and datapath registers. div_out is written on the edge
    // that enters DONE so the result is already visible while
    // div_valid_out is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 7'd0;
            rem_r     <= 64'd0;
            quo_r     <= 64'd0;
            dvs_r     <= 64'd0;
            qsign_r   <= 1'b0;
            rsign_r   <= 1'b0;
            w_r       <= 1'b0;
            sel_rem_r <= 1'b0;
            valid_r   <= 1'b0;
            out_r     <= 64'd0;
        end else begin
            valid_r <= 1'b0;
            if (div_flush) begin
                // a pulse already high in DONE still completes this cycle
                state_r <= ST_IDLE;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (accept_s) begin
                            w_r       <= op_w_s;
                            sel_rem_r <= op_rem_s;
                            qsign_r   <= sign1_s ^ sign2_s;
                            rsign_r   <= sign1_s;
                            dvs_r     <= mag2_s;
                            rem_r     <= 64'd0;
                            // W dividends sit in the upper half so the 32
                            // shifts leave the quotient in the lower half
                            if (op_w_s) begin
                                quo_r <= {mag1_s[31:0], 32'd0};
                                cnt_r <= 7'd32;
                            end else begin
                                quo_r <= mag1_s;
                                cnt_r <= 7'd64;
                            end
                            if (div_zero_s || ovf_s) begin
                                state_r <= ST_DONE;
                                valid_r <= 1'b1;
                                out_r   <= spec_res_s;
                            end else begin
                                state_r <= ST_BUSY;
                            end
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_BUSY: begin
                        rem_r <= rem_nxt_s;
                        quo_r <= quo_nxt_s;
                        cnt_r <= cnt_r - 7'd1;
                        if (cnt_r == 7'd1) begin
                            state_r <= ST_DONE;
                            valid_r <= 1'b1;
                            out_r   <= busy_res_s;
                        end else begin
                            state_r <= ST_BUSY;
                        end
                    end
                    ST_DONE: begin
                        state_r <= ST_IDLE;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
